// File: rtl/thunderbird_lamp_monitor_if.sv
// Lamp bus between the tail-light sequencer and its monitor.
//   step : one lamp-update sample per cycle it is high
//   L    : left lamps, bit0 inner .. bit2 outer
//   R    : right lamps, bit2 inner .. bit0 outer
// master drives the bus (sequencer or testbench); slave observes it (monitor).
interface thunderbird_lamp_monitor_if;
  localparam int unsigned LAMP_W = 3;

  logic              step;
  logic [LAMP_W-1:0] L;
  logic [LAMP_W-1:0] R;

  modport master (output step, output L, output R);
  modport slave  (input  step, input  L, input  R);
endinterface

// File: rtl/thunderbird_lamp_monitor.sv
// Checker for the thunderbird tail-light lamp bus. Decodes turn direction and
// phase on every step, counts completed flash cycles, flags illegal samples and
// holds off in a resync state until both buses go dark.
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   lamp            : lamp bus (step, L, R), slave side
//   clear           : synchronous clear of both counters
//   turn_left/right : direction of the sequence in progress
//   phase           : lamps lit in the active sequence (0..3)
//   in_sync         : low while waiting to resynchronise after an error
//   error           : one-cycle pulse per illegal sample
//   cycle_count     : completed full sequences, saturating
//   error_count     : illegal samples, saturating
module thunderbird_lamp_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  thunderbird_lamp_monitor_if.slave   lamp,
  input  logic                        clear,
  output logic                        turn_left,
  output logic                        turn_right,
  output logic [1:0]                  phase,
  output logic                        in_sync,
  output logic                        error,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CNT_W-1:0]            error_count
);

  localparam int unsigned LAMP_W  = 3;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEFT1  = 3'd1,
    LEFT2  = 3'd2,
    LEFT3  = 3'd3,
    RIGHT1 = 3'd4,
    RIGHT2 = 3'd5,
    RIGHT3 = 3'd6,
    SYNC   = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic                 error_d;
  logic [CNT_W-1:0]     cycle_count_d, error_count_d;
  logic                 turn_left_d, turn_right_d, in_sync_d;
  logic [PHASE_W-1:0]   phase_d;

  // Sample classification; each legal code requires the other bus dark.
  logic l_dark, r_dark;
  logic s_off, s_l1, s_l2, s_l3, s_r1, s_r2, s_r3;

  always_comb begin
    l_dark = (lamp.L == LAMP_W'(0));
    r_dark = (lamp.R == LAMP_W'(0));
    s_off  = l_dark && r_dark;
    s_l1   = r_dark && (lamp.L == 3'b001);
    s_l2   = r_dark && (lamp.L == 3'b011);
    s_l3   = r_dark && (lamp.L == 3'b111);
    s_r1   = l_dark && (lamp.R == 3'b100);
    s_r2   = l_dark && (lamp.R == 3'b110);
    s_r3   = l_dark && (lamp.R == 3'b111);
  end

  // Next state, error pulse, counter updates and decoded outputs.
  always_comb begin
    logic is_left, is_right, cyc_inc;

    state_d       = state_q;
    error_d       = 1'b0;
    cyc_inc       = 1'b0;
    cycle_count_d = cycle_count;
    error_count_d = error_count;
    is_left       = (state_q == LEFT1) || (state_q == LEFT2) || (state_q == LEFT3);
    is_right      = (state_q == RIGHT1) || (state_q == RIGHT2) || (state_q == RIGHT3);

    if (lamp.step) begin
      if (state_q == SYNC) begin
        // Only a dark sample ends resync; everything else is ignored silently.
        if (s_off) state_d = IDLE;
      end else if (s_off) begin
        state_d = IDLE;
        cyc_inc = (state_q == LEFT3) || (state_q == RIGHT3);
      end else if (s_l1 && (state_q == IDLE || is_right || state_q == LEFT1)) begin
        state_d = LEFT1;
      end else if (s_r1 && (state_q == IDLE || is_left || state_q == RIGHT1)) begin
        state_d = RIGHT1;
      end else if (s_l2 && (state_q == LEFT1 || state_q == LEFT2)) begin
        state_d = LEFT2;
      end else if (s_l3 && (state_q == LEFT2 || state_q == LEFT3)) begin
        state_d = LEFT3;
      end else if (s_r2 && (state_q == RIGHT1 || state_q == RIGHT2)) begin
        state_d = RIGHT2;
      end else if (s_r3 && (state_q == RIGHT2 || state_q == RIGHT3)) begin
        state_d = RIGHT3;
      end else begin
        state_d = SYNC;
        error_d = 1'b1;
      end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    if (clear) begin
      cycle_count_d = '0;
      error_count_d = '0;
    end else begin
      if (cyc_inc && (cycle_count != {CNT_W{1'b1}}))
        cycle_count_d = cycle_count + CNT_W'(1);
      if (error_d && (error_count != {CNT_W{1'b1}}))
        error_count_d = error_count + CNT_W'(1);
    end

    turn_left_d  = (state_d == LEFT1) || (state_d == LEFT2) || (state_d == LEFT3);
    turn_right_d = (state_d == RIGHT1) || (state_d == RIGHT2) || (state_d == RIGHT3);
    in_sync_d    = (state_d != SYNC);
    unique case (state_d)
      LEFT1, RIGHT1: phase_d = PHASE_W'(1);
      LEFT2, RIGHT2: phase_d = PHASE_W'(2);
      LEFT3, RIGHT3: phase_d = PHASE_W'(3);
      default:       phase_d = PHASE_W'(0);
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      turn_left   <= 1'b0;
      turn_right  <= 1'b0;
      phase       <= '0;
      in_sync     <= 1'b1;
      error       <= 1'b0;
      cycle_count <= '0;
      error_count <= '0;
    end else begin
      state_q     <= state_d;
      turn_left   <= turn_left_d;
      turn_right  <= turn_right_d;
      phase       <= phase_d;
      in_sync     <= in_sync_d;
      error       <= error_d;
      cycle_count <= cycle_count_d;
      error_count <= error_count_d;
    end
  end

endmodule

// File: tb/tb_thunderbird_lamp_monitor.sv
// Directed bench for thunderbird_lamp_monitor: a vector table walked one sample
// per cycle, then saturation, and asynchronous reset mid-sequence.
module tb_thunderbird_lamp_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned NVEC  = 30;

  logic             clock;
  logic             reset_n;
  logic             clear;
  logic             turn_left, turn_right, in_sync, error;
  logic [1:0]       phase;
  logic [CNT_W-1:0] cycle_count, error_count;

  int checks;
  int failures;

  thunderbird_lamp_monitor_if lif ();

  thunderbird_lamp_monitor #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .lamp        (lif.slave),
    .clear       (clear),
    .turn_left   (turn_left),
    .turn_right  (turn_right),
    .phase       (phase),
    .in_sync     (in_sync),
    .error       (error),
    .cycle_count (cycle_count),
    .error_count (error_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       step;
    logic [2:0] l;
    logic [2:0] r;
    logic       clr;
    logic       tl;
    logic       tr;
    logic [1:0] ph;
    logic       sync;
    logic       err;
    int         cyc;
    int         ecnt;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(logic s, logic [2:0] l, logic [2:0] r, logic c,
                              logic tl, logic tr, logic [1:0] ph, logic sy,
                              logic er, int cy, int ec);
    vec_t v;
    v.step = s; v.l = l; v.r = r; v.clr = c;
    v.tl = tl; v.tr = tr; v.ph = ph; v.sync = sy; v.err = er;
    v.cyc = cy; v.ecnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic tl, input logic tr,
                         input logic [1:0] ph, input logic sy, input logic er,
                         input int cy, input int ec);
    chk({tag, ".turn_left"},   int'(turn_left),   int'(tl));
    chk({tag, ".turn_right"},  int'(turn_right),  int'(tr));
    chk({tag, ".phase"},       int'(phase),       int'(ph));
    chk({tag, ".in_sync"},     int'(in_sync),     int'(sy));
    chk({tag, ".error"},       int'(error),       int'(er));
    chk({tag, ".cycle_count"}, int'(cycle_count), cy);
    chk({tag, ".error_count"}, int'(error_count), ec);
  endtask

  // Drive one cycle's inputs on the falling edge, then settle past the rising edge.
  task automatic apply(input logic s, input logic [2:0] l, input logic [2:0] r,
                       input logic c);
    @(negedge clock);
    lif.step = s; lif.L = l; lif.R = r; clear = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //               step L       R       clr  tl tr ph sy er cyc ec
    vecs[0]  = mk(1, 3'b001, 3'b000, 0,   1, 0, 1, 1, 0, 0, 0);
    vecs[1]  = mk(1, 3'b011, 3'b000, 0,   1, 0, 2, 1, 0, 0, 0);
    vecs[2]  = mk(1, 3'b111, 3'b000, 0,   1, 0, 3, 1, 0, 0, 0);
    vecs[3]  = mk(1, 3'b000, 3'b000, 0,   0, 0, 0, 1, 0, 1, 0);
    vecs[4]  = mk(0, 3'b101, 3'b011, 0,   0, 0, 0, 1, 0, 1, 0); // no step: ignored
    vecs[5]  = mk(1, 3'b001, 3'b000, 0,   1, 0, 1, 1, 0, 1, 0);
    vecs[6]  = mk(1, 3'b001, 3'b000, 0,   1, 0, 1, 1, 0, 1, 0); // repeat holds
    vecs[7]  = mk(1, 3'b011, 3'b000, 0,   1, 0, 2, 1, 0, 1, 0);
    vecs[8]  = mk(1, 3'b000, 3'b100, 0,   0, 1, 1, 1, 0, 1, 0); // switch to right
    vecs[9]  = mk(1, 3'b000, 3'b110, 0,   0, 1, 2, 1, 0, 1, 0);
    vecs[10] = mk(1, 3'b000, 3'b111, 0,   0, 1, 3, 1, 0, 1, 0);
    vecs[11] = mk(1, 3'b001, 3'b000, 0,   1, 0, 1, 1, 0, 1, 0); // switch to left
    vecs[12] = mk(1, 3'b000, 3'b000, 0,   0, 0, 0, 1, 0, 1, 0); // cancel, no count
    vecs[13] = mk(1, 3'b011, 3'b000, 0,   0, 0, 0, 0, 1, 1, 1); // skipped phase
    vecs[14] = mk(1, 3'b111, 3'b000, 0,   0, 0, 0, 0, 0, 1, 1);
    vecs[15] = mk(1, 3'b001, 3'b000, 0,   0, 0, 0, 0, 0, 1, 1);
    vecs[16] = mk(1, 3'b000, 3'b000, 0,   0, 0, 0, 1, 0, 1, 1); // resync
    vecs[17] = mk(1, 3'b001, 3'b100, 0,   0, 0, 0, 0, 1, 1, 2); // both buses lit
    vecs[18] = mk(1, 3'b000, 3'b000, 0,   0, 0, 0, 1, 0, 1, 2);
    vecs[19] = mk(1, 3'b001, 3'b000, 0,   1, 0, 1, 1, 0, 1, 2);
    vecs[20] = mk(1, 3'b111, 3'b000, 0,   0, 0, 0, 0, 1, 1, 3); // LEFT1 -> 111 skip
    vecs[21] = mk(1, 3'b000, 3'b000, 0,   0, 0, 0, 1, 0, 1, 3);
    vecs[22] = mk(1, 3'b000, 3'b100, 0,   0, 1, 1, 1, 0, 1, 3);
    vecs[23] = mk(1, 3'b000, 3'b110, 0,   0, 1, 2, 1, 0, 1, 3);
    vecs[24] = mk(1, 3'b000, 3'b111, 0,   0, 1, 3, 1, 0, 1, 3);
    vecs[25] = mk(1, 3'b000, 3'b110, 0,   0, 0, 0, 0, 1, 1, 4); // backward step
    vecs[26] = mk(1, 3'b000, 3'b000, 0,   0, 0, 0, 1, 0, 1, 4);
    vecs[27] = mk(1, 3'b010, 3'b000, 1,   0, 0, 0, 0, 1, 0, 0); // error + clear
    vecs[28] = mk(0, 3'b000, 3'b000, 0,   0, 0, 0, 0, 0, 0, 0); // no step: stays SYNC
    vecs[29] = mk(1, 3'b000, 3'b000, 0,   0, 0, 0, 1, 0, 0, 0);

    lif.step = 1'b0; lif.L = 3'b000; lif.R = 3'b000; clear = 1'b0;
    reset_n  = 1'b0;
    #12;
    chk_all("reset", 0, 0, 2'd0, 1, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].step, vecs[i].l, vecs[i].r, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].tl, vecs[i].tr, vecs[i].ph,
              vecs[i].sync, vecs[i].err, vecs[i].cyc, vecs[i].ecnt);
    end

    // 300 full right cycles from zero: count must stop at 255.
    for (int n = 1; n <= 300; n++) begin
      apply(1, 3'b000, 3'b100, 0);
      apply(1, 3'b000, 3'b110, 0);
      apply(1, 3'b000, 3'b111, 0);
      apply(1, 3'b000, 3'b000, 0);
      if (n == 254) chk("sat.cyc254", int'(cycle_count), 254);
      if (n == 256) chk("sat.cyc256", int'(cycle_count), 255);
    end
    chk("sat.cycle_count", int'(cycle_count), 255);
    chk("sat.error_count", int'(error_count), 0);
    chk("sat.error",       int'(error),       0);

    // Asynchronous reset while in LEFT3 with a step pending.
    apply(1, 3'b001, 3'b000, 0);
    apply(1, 3'b011, 3'b000, 0);
    apply(1, 3'b111, 3'b000, 0);
    chk_all("left3", 1, 0, 2'd3, 1, 0, 255, 0);
    @(negedge clock);
    lif.step = 1'b1; lif.L = 3'b111; lif.R = 3'b000;
    reset_n  = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 2'd0, 1, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_all("post_rst_111", 0, 0, 2'd0, 0, 1, 0, 1);
    apply(0, 3'b000, 3'b000, 0);
    chk("post_rst.err_pulse", int'(error), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
